// File: rtl/ac_motor_pkg.sv
// Shared constants and helpers for the SVPWM sequencer: switching vectors,
// FSM state encoding and the sector lookup.
package ac_motor_pkg;

    // Switch states are {u,v,w}; 1 means the high-side switch is commanded on.
    localparam logic [2:0] V0 = 3'b000;
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;
    localparam logic [2:0] V7 = 3'b111;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LATCH = 4'd1;
    localparam logic [3:0] ST_SEG0  = 4'd2;
    localparam logic [3:0] ST_SEG1  = 4'd3;
    localparam logic [3:0] ST_SEG2  = 4'd4;
    localparam logic [3:0] ST_SEG3  = 4'd5;
    localparam logic [3:0] ST_SEG4  = 4'd6;
    localparam logic [3:0] ST_SEG5  = 4'd7;
    localparam logic [3:0] ST_SEG6  = 4'd8;

    typedef struct packed {
        logic [2:0] vec_a;
        logic [2:0] vec_b;
        logic       a_uses_t2;
    } seg_pair_t;

    // Odd sectors swap A/B so that exactly one leg switches per boundary.
    // Invalid sectors map both active vectors to V0.
    function automatic seg_pair_t sector_lookup(input logic [2:0] sector);
        seg_pair_t p;
        p = '{vec_a: V0, vec_b: V0, a_uses_t2: 1'b0};
        case (sector)
            3'd0: p = '{vec_a: V1, vec_b: V2, a_uses_t2: 1'b0};
            3'd1: p = '{vec_a: V3, vec_b: V2, a_uses_t2: 1'b1};
            3'd2: p = '{vec_a: V3, vec_b: V4, a_uses_t2: 1'b0};
            3'd3: p = '{vec_a: V5, vec_b: V4, a_uses_t2: 1'b1};
            3'd4: p = '{vec_a: V5, vec_b: V6, a_uses_t2: 1'b0};
            3'd5: p = '{vec_a: V1, vec_b: V6, a_uses_t2: 1'b1};
            default: p = '{vec_a: V0, vec_b: V0, a_uses_t2: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ac_motor_dead_time.sv
// Per-phase dead-time insertion: the side being turned off drops at once,
// the side being turned on waits DEAD stable cycles of the command.
module ac_motor_dead_time #(
    parameter int DEAD = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_cmd,
    output logic o_hi,
    output logic o_lo
);
    localparam int CW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic          r_run;
    logic          r_cmd_q;
    logic [CW-1:0] r_cnt;
    logic          w_changed;
    logic          w_settled;

    assign w_changed = (i_cmd != r_cmd_q);
    // r_cnt counts cycles the command has been stable since it last changed
    // (or since the phase started running), saturating at DEAD.
    assign w_settled = (DEAD == 0) ? 1'b1 : (!w_changed && (r_cnt == DEAD_C));

    always_ff @(posedge clk) begin
        if (!reset_n || !i_en) begin
            r_run   <= 1'b0;
            r_cmd_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_run   <= 1'b1;
            r_cmd_q <= i_cmd;
            if (!r_run) begin
                r_cnt <= '0;
            end else if (w_changed) begin
                r_cnt <= CW'(1);
            end else if (r_cnt != DEAD_C) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_hi = r_run & i_cmd & w_settled;
    assign o_lo = r_run & ~i_cmd & w_settled;

endmodule

// File: rtl/ac_motor_svpwm_sequencer.sv
// Symmetric 7-segment SVPWM sequencer: latches sector/vector times once per
// period, plays out the switching vectors and drives the six gates.
module ac_motor_svpwm_sequencer
    import ac_motor_pkg::*;
#(
    parameter int TW   = 15,
    parameter int DEAD = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [2:0]    sector,
    input  logic [TW-1:0] t0,
    input  logic [TW-1:0] t1,
    input  logic [TW-1:0] t2,
    input  logic [TW-1:0] t7,
    output logic          sample,
    output logic [2:0]    vector,
    output logic          gate_u_hi,
    output logic          gate_u_lo,
    output logic          gate_v_hi,
    output logic          gate_v_lo,
    output logic          gate_w_hi,
    output logic          gate_w_lo,
    output logic          fault,
    output logic [3:0]    state_dbg
);
    logic [3:0]    r_state;
    logic [2:0]    r_vector;
    logic          r_fault;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] r_t0, r_t1, r_t2, r_t7;
    seg_pair_t     r_pair;

    logic          w_latch;
    seg_pair_t     w_pair;
    logic [TW-1:0] w_t0, w_t1, w_t2, w_t7, w_ta, w_tb;
    logic [TW-1:0] w_dur [7];
    logic [2:0]    w_code [7];
    logic [2:0]    w_start;
    logic [2:0]    w_idx;
    logic          w_found;

    assign w_latch = (r_state == ST_LATCH);

    // During LATCH the segment table is fed straight from the inputs so the
    // first non-zero segment can be entered on the very next cycle.
    always_comb begin
        w_pair = w_latch ? sector_lookup(sector) : r_pair;
        w_t0   = w_latch ? t0 : r_t0;
        w_t1   = w_latch ? t1 : r_t1;
        w_t2   = w_latch ? t2 : r_t2;
        w_t7   = w_latch ? t7 : r_t7;
        w_ta   = w_pair.a_uses_t2 ? w_t2 : w_t1;
        w_tb   = w_pair.a_uses_t2 ? w_t1 : w_t2;
    end

    always_comb begin
        w_dur[0]  = w_t0 >> 1;
        w_dur[1]  = w_ta >> 1;
        w_dur[2]  = w_tb >> 1;
        w_dur[3]  = w_t7;
        w_dur[4]  = w_tb - (w_tb >> 1);
        w_dur[5]  = w_ta - (w_ta >> 1);
        w_dur[6]  = w_t0 - (w_t0 >> 1);
        w_code[0] = V0;
        w_code[1] = w_pair.vec_a;
        w_code[2] = w_pair.vec_b;
        w_code[3] = V7;
        w_code[4] = w_pair.vec_b;
        w_code[5] = w_pair.vec_a;
        w_code[6] = V0;
    end

    // Zero-length segments are skipped by searching forward for the next
    // non-zero one; a start index of 7 (after SEG6) finds nothing.
    always_comb begin
        w_start = w_latch ? 3'd0 : 3'(r_state - 4'd1);
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (!w_found && (3'(k) >= w_start) && (w_dur[k] != '0)) begin
                w_found = 1'b1;
                w_idx   = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_vector <= V0;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
            r_t0     <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_t7     <= '0;
            r_pair   <= '0;
        end else if (!enable) begin
            r_state  <= ST_IDLE;
            r_vector <= V0;
            r_cnt    <= '0;
        end else begin
            if (w_latch) begin
                r_t0   <= t0;
                r_t1   <= t1;
                r_t2   <= t2;
                r_t7   <= t7;
                r_pair <= w_pair;
                if (sector > 3'd5) begin
                    r_fault <= 1'b1;
                end
            end
            if (r_state == ST_IDLE) begin
                r_state <= ST_LATCH;
            end else if (w_latch || (r_cnt == '0)) begin
                if (w_found) begin
                    r_state  <= ST_SEG0 + {1'b0, w_idx};
                    r_vector <= w_code[w_idx];
                    r_cnt    <= w_dur[w_idx] - TW'(1);
                end else begin
                    r_state <= ST_LATCH;
                end
            end else begin
                r_cnt <= r_cnt - TW'(1);
            end
        end
    end

    assign sample    = w_latch;
    assign vector    = r_vector;
    assign fault     = r_fault;
    assign state_dbg = r_state;

    ac_motor_dead_time #(.DEAD(DEAD)) u_dt_u (
        .clk(clk), .reset_n(reset_n), .i_en(enable), .i_cmd(r_vector[2]),
        .o_hi(gate_u_hi), .o_lo(gate_u_lo)
    );
    ac_motor_dead_time #(.DEAD(DEAD)) u_dt_v (
        .clk(clk), .reset_n(reset_n), .i_en(enable), .i_cmd(r_vector[1]),
        .o_hi(gate_v_hi), .o_lo(gate_v_lo)
    );
    ac_motor_dead_time #(.DEAD(DEAD)) u_dt_w (
        .clk(clk), .reset_n(reset_n), .i_en(enable), .i_cmd(r_vector[0]),
        .o_hi(gate_w_hi), .o_lo(gate_w_lo)
    );

endmodule

// File: tb/tb_ac_motor_svpwm_sequencer.sv
// Directed bench for the SVPWM sequencer: one instance without dead time for
// vector/gate sequencing, one with DEAD=8 for gate timing.
module tb_ac_motor_svpwm_sequencer;
    import ac_motor_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [2:0]  sector;
    logic [14:0] t0, t1, t2, t7;

    logic       a_sample, a_fault, a_uh, a_ul, a_vh, a_vl, a_wh, a_wl;
    logic [2:0] a_vector;
    logic [3:0] a_state;
    logic       b_sample, b_fault, b_uh, b_ul, b_vh, b_vl, b_wh, b_wl;
    logic [2:0] b_vector;
    logic [3:0] b_state;

    logic [5:0] a_gates;
    logic [5:0] b_gates;
    assign a_gates = {a_uh, a_ul, a_vh, a_vl, a_wh, a_wl};
    assign b_gates = {b_uh, b_ul, b_vh, b_vl, b_wh, b_wl};

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    ac_motor_svpwm_sequencer #(.TW(15), .DEAD(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sector(sector),
        .t0(t0), .t1(t1), .t2(t2), .t7(t7),
        .sample(a_sample), .vector(a_vector),
        .gate_u_hi(a_uh), .gate_u_lo(a_ul), .gate_v_hi(a_vh), .gate_v_lo(a_vl),
        .gate_w_hi(a_wh), .gate_w_lo(a_wl), .fault(a_fault), .state_dbg(a_state)
    );

    ac_motor_svpwm_sequencer #(.TW(15), .DEAD(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sector(sector),
        .t0(t0), .t1(t1), .t2(t2), .t7(t7),
        .sample(b_sample), .vector(b_vector),
        .gate_u_hi(b_uh), .gate_u_lo(b_ul), .gate_v_hi(b_vh), .gate_v_lo(b_vl),
        .gate_w_hi(b_wh), .gate_w_lo(b_wl), .fault(b_fault), .state_dbg(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_gates(input logic [2:0] v);
        return {v[2], ~v[2], v[1], ~v[1], v[0], ~v[0]};
    endfunction

    task automatic push(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic set_in(input logic [2:0] s, input int a, input int b, input int c, input int d);
        sector = s;
        t0 = 15'(a);
        t1 = 15'(b);
        t2 = 15'(c);
        t7 = 15'(d);
    endtask

    // Starts in a LATCH cycle, plays the queued vectors, ends in the next LATCH.
    task automatic run_period(input string tag, input bit chk_w);
        logic [2:0] ev;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            ev = exp_q[i];
            if (i == 3) begin
                sector = 3'd7;
                t0     = 15'd1;
            end
            check({tag, "_vec"}, 8'(a_vector), 8'(ev));
            check({tag, "_gates"}, 8'(a_gates), 8'(exp_gates(ev)));
            if (chk_w && i <= 9) check({tag, "_b_wlo"}, 8'(b_wl), 8'(i == 7 || i == 8));
        end
        tick();
        check({tag, "_sample"}, 8'(a_sample), 8'd1);
        check({tag, "_state"}, 8'(a_state), 8'(ST_LATCH));
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        set_in(3'd0, 0, 0, 0, 0);
        repeat (2) tick();
        check("rst_sample", 8'(a_sample), 8'd0);
        check("rst_vector", 8'(a_vector), 8'd0);
        check("rst_gates_a", 8'(a_gates), 8'd0);
        check("rst_gates_b", 8'(b_gates), 8'd0);
        check("rst_fault", 8'(a_fault), 8'd0);
        check("rst_state", 8'(a_state), 8'(ST_IDLE));

        // Sector 0, 8/6/4/2.
        set_in(3'd0, 8, 6, 4, 2);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check("t1_first_sample", 8'(a_sample), 8'd1);
        check("t1_b_gates_latch", 8'(b_gates), 8'd0);
        push(V0, 4); push(V1, 3); push(V2, 2); push(V7, 2); push(V2, 2); push(V1, 3); push(V0, 4);
        run_period("t1", 1'b0);
        check("t1_fault", 8'(a_fault), 8'd0);

        // Sector 1, same times: A/B swapped.
        set_in(3'd1, 8, 6, 4, 2);
        push(V0, 4); push(V3, 2); push(V2, 3); push(V7, 2); push(V2, 3); push(V3, 2); push(V0, 4);
        run_period("t2", 1'b0);
        check("t2_fault", 8'(a_fault), 8'd0);

        // Sector 2 with skipped t1 and t7 segments.
        set_in(3'd2, 5, 0, 3, 0);
        push(V0, 2); push(V4, 1); push(V4, 2); push(V0, 3);
        run_period("t3", 1'b0);

        // All-zero times: LATCH only.
        set_in(3'd0, 0, 0, 0, 0);
        tick();
        check("zero_sample", 8'(a_sample), 8'd1);
        check("zero_vec", 8'(a_vector), 8'd0);
        tick();
        check("zero_sample2", 8'(a_sample), 8'd1);

        // Dead time: u high for 3 cycles only, hi never asserts.
        set_in(3'd0, 16, 3, 0, 0);
        for (int i = 0; i < 19; i++) begin
            tick();
            check("t4_vec", 8'(a_vector), 8'((i >= 8 && i < 11) ? 3'b100 : 3'b000));
            check("t4_uhi", 8'(b_uh), 8'd0);
            check("t4_ulo", 8'(b_ul), 8'(i < 8));
        end
        tick();
        check("t4_latch_sample", 8'(a_sample), 8'd1);
        check("t4_ulo_return", 8'(b_ul), 8'd1);

        // Dead time: u high for 20 cycles, hi after 8.
        set_in(3'd0, 2, 20, 0, 0);
        for (int i = 0; i < 22; i++) begin
            tick();
            check("t4b_uhi", 8'(b_uh), 8'(i >= 9 && i <= 20));
            check("t4b_ulo", 8'(b_ul), 8'(i == 0));
        end
        tick();
        check("t4b_latch_sample", 8'(a_sample), 8'd1);
        check("t4b_uhi_end", 8'(b_uh), 8'd0);
        check("t4b_ulo_end", 8'(b_ul), 8'd0);

        // Invalid sector: zero vectors except the V7 segment, sticky fault.
        set_in(3'd7, 8, 6, 4, 2);
        push(V0, 9); push(V7, 2); push(V0, 9);
        run_period("t5", 1'b0);
        check("t5_fault_set", 8'(a_fault), 8'd1);
        set_in(3'd0, 2, 2, 2, 2);
        push(V0, 1); push(V1, 1); push(V2, 1); push(V7, 2); push(V2, 1); push(V1, 1); push(V0, 1);
        run_period("t5b", 1'b0);
        check("t5_fault_sticky", 8'(a_fault), 8'd1);

        // Enable dropped in SEG2, then re-enabled.
        set_in(3'd0, 8, 6, 4, 2);
        repeat (8) tick();
        check("t6_in_seg2", 8'(a_vector), 8'(V2));
        enable = 1'b0;
        tick();
        check("t6_off_state", 8'(a_state), 8'(ST_IDLE));
        check("t6_off_vec", 8'(a_vector), 8'd0);
        check("t6_off_gates_a", 8'(a_gates), 8'd0);
        check("t6_off_gates_b", 8'(b_gates), 8'd0);
        check("t6_off_sample", 8'(a_sample), 8'd0);
        check("t6_off_fault", 8'(a_fault), 8'd1);
        tick();
        check("t6_off_state2", 8'(a_state), 8'(ST_IDLE));
        enable = 1'b1;
        tick();
        check("t6_re_sample", 8'(a_sample), 8'd1);
        check("t6_re_b_wlo", 8'(b_wl), 8'd0);
        set_in(3'd0, 8, 6, 4, 2);
        push(V0, 4); push(V1, 3); push(V2, 2); push(V7, 2); push(V2, 2); push(V1, 3); push(V0, 4);
        run_period("t6", 1'b1);

        // Reset mid-period.
        set_in(3'd0, 8, 6, 4, 2);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("t7_rst_state", 8'(a_state), 8'(ST_IDLE));
        check("t7_rst_vec", 8'(a_vector), 8'd0);
        check("t7_rst_sample", 8'(a_sample), 8'd0);
        check("t7_rst_fault", 8'(a_fault), 8'd0);
        check("t7_rst_gates_a", 8'(a_gates), 8'd0);
        check("t7_rst_gates_b", 8'(b_gates), 8'd0);
        reset_n = 1'b1;
        tick();
        check("t7_restart_sample", 8'(a_sample), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
